instr_fetch_unit: RTL and testbench

//  Fetch stage directly downstream of the PC register. Computes the PC register's next-PC input, issues

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/instr_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared constants and the IF/ID entry type for the fetch stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int N_BITS  = 32;
  localparam int INSTR_W = 32;
  localparam logic [N_BITS-1:0] RESET_PC = 32'h0040_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [N_BITS-1:0]  pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module  : fetch_fifo
// Brief   : Synchronous circular FIFO with flush, occupancy count and flags.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter int               CNT_W     = $clog2(DEPTH + 1),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_do_push = push && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  // Storage resets too, so the head presents a defined entry straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : Fetch stage: next-PC, credit-limited imem requests, IF/ID buffer.
//           Optional FETCH_PERF_CNT_EN adds fetch_stall_cnt_o.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                N_BITS     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [N_BITS-1:0] RESET_PC   = fetch_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] pc_i,
  output logic [N_BITS-1:0] next_pc_o,
  input  logic              redirect_i,
  input  logic [N_BITS-1:0] redirect_target_i,
  output logic              imem_req_o,
  output logic [N_BITS-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              ifid_valid_o,
  input  logic              ifid_ready_i,
  output logic [31:0]       ifid_instr_o,
  output logic [N_BITS-1:0] ifid_pc_o,
  output logic [N_BITS-1:0] ifid_pc4_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;
  localparam fetch_entry_t C_ENTRY_RST = '{instr: '0, pc: RESET_PC};

  logic [N_BITS-1:0] w_inf_head;
  logic [CNT_W-1:0]  w_inf_count;
  logic              w_inf_full;
  logic              w_inf_empty;
  fetch_entry_t      w_ifid_push_data;
  fetch_entry_t      w_ifid_head;
  logic [CNT_W-1:0]  w_ifid_count;
  logic              w_ifid_full;
  logic              w_ifid_empty;
  logic [CRD_W-1:0]  w_occupancy;
  logic              w_accept;
  logic              w_ifid_push;
  logic              w_ifid_pop;
  logic [CNT_W-1:0]  r_discard;

  // Credit counts every slot already promised: in flight plus buffered, less a slot freed by decode now.
  assign w_occupancy = CRD_W'(w_inf_count) + CRD_W'(w_ifid_count)
                     - CRD_W'(ifid_valid_o && ifid_ready_i);
  assign imem_req_o  = reset && !redirect_i && (w_occupancy < CRD_W'(FIFO_DEPTH));
  assign imem_addr_o = pc_i;
  assign w_accept    = imem_req_o && imem_gnt_i;

  always_comb begin
    next_pc_o = pc_i;
    if (!reset)          next_pc_o = RESET_PC;
    else if (redirect_i) next_pc_o = {redirect_target_i[N_BITS-1:2], 2'b00};
    else if (w_accept)   next_pc_o = pc_i + N_BITS'(4);
  end

  fetch_fifo #(
    .WIDTH     (N_BITS),
    .DEPTH     (FIFO_DEPTH),
    .CNT_W     (CNT_W),
    .RESET_VAL ('0)
  ) u_inflight_q (
    .clk       (clk),
    .reset     (reset),
    .push      (w_accept),
    .push_data (pc_i),
    .pop       (imem_rvalid_i),
    .flush     (1'b0),
    .head_data (w_inf_head),
    .count     (w_inf_count),
    .full      (w_inf_full),
    .empty     (w_inf_empty)
  );

  // Responses to fetches issued before a redirect still drain through the in-flight queue, but are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_discard <= '0;
    end else if (redirect_i) begin
      r_discard <= w_inf_count - CNT_W'(imem_rvalid_i);
    end else if (imem_rvalid_i && (r_discard != '0)) begin
      r_discard <= r_discard - CNT_W'(1);
    end
  end

  assign w_ifid_push            = imem_rvalid_i && !redirect_i && (r_discard == '0);
  assign w_ifid_pop             = ifid_valid_o && ifid_ready_i && !redirect_i;
  assign w_ifid_push_data.instr = imem_rdata_i;
  assign w_ifid_push_data.pc    = w_inf_head;

  fetch_fifo #(
    .WIDTH     ($bits(fetch_entry_t)),
    .DEPTH     (FIFO_DEPTH),
    .CNT_W     (CNT_W),
    .RESET_VAL (C_ENTRY_RST)
  ) u_ifid_q (
    .clk       (clk),
    .reset     (reset),
    .push      (w_ifid_push),
    .push_data (w_ifid_push_data),
    .pop       (w_ifid_pop),
    .flush     (redirect_i),
    .head_data (w_ifid_head),
    .count     (w_ifid_count),
    .full      (w_ifid_full),
    .empty     (w_ifid_empty)
  );

  assign ifid_valid_o = !w_ifid_empty;
  assign ifid_instr_o = w_ifid_head.instr;
  assign ifid_pc_o    = w_ifid_head.pc;
  assign ifid_pc4_o   = w_ifid_head.pc + N_BITS'(4);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                         r_stall_cnt <= '0;
    else if (!ifid_valid_o && (r_stall_cnt != '1))      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign fetch_stall_cnt_o = r_stall_cnt;
`endif

  a_ifid_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(w_ifid_push && w_ifid_full && !w_ifid_pop));
  a_inflight_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(w_accept && w_inf_full && !imem_rvalid_i));
  a_no_orphan_response: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rvalid_i && w_inf_empty));

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module  : tb_instr_fetch_unit
// Brief   : Queue-based reference model, directed pins and random traffic.
//           FETCH_PERF_CNT_EN enables the stall-counter checks.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic [31:0] next_pc_o;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        ifid_valid_o;
  logic        ifid_ready_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_stall_cnt_o;
`endif

  int checks = 0;
  int fails  = 0;

  instr_fetch_unit #(.N_BITS(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_i              (pc_i),
    .next_pc_o         (next_pc_o),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .ifid_valid_o      (ifid_valid_o),
    .ifid_ready_i      (ifid_ready_i),
    .ifid_instr_o      (ifid_instr_o),
    .ifid_pc_o         (ifid_pc_o),
    .ifid_pc4_o        (ifid_pc4_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_stall_cnt_o (fetch_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Environment: the PC register the fetch unit drives.
  always @(posedge clk or negedge reset)
    if (!reset) pc_i <= RST_PC;
    else        pc_i <= next_pc_o;

  typedef struct { logic [31:0] pc; bit stale; } inf_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  inf_t        m_inf[$];
  ent_t        m_buf[$];
  logic [31:0] m_stall;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit m_req();
    int used;
    used = m_inf.size() + m_buf.size() - ((m_buf.size() > 0 && ifid_ready_i) ? 1 : 0);
    return reset && !redirect_i && (used < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction-level step per clock edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_inf.delete();
      m_buf.delete();
      m_stall = 32'd0;
    end else begin
      bit   acc;
      inf_t r;
      acc = m_req() && imem_gnt_i;
      if (m_buf.size() == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (redirect_i) begin
        m_buf.delete();
        if (imem_rvalid_i) r = m_inf.pop_front();
        foreach (m_inf[i]) m_inf[i].stale = 1'b1;
      end else begin
        if (m_buf.size() > 0 && ifid_ready_i) void'(m_buf.pop_front());
        if (imem_rvalid_i) begin
          r = m_inf.pop_front();
          if (!r.stale) m_buf.push_back('{instr: imem_rdata_i, pc: r.pc});
        end
      end
      if (acc) m_inf.push_back('{pc: pc_i, stale: 1'b0});
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    bit          e_req;
    logic [31:0] e_next;
    e_req = m_req();
    if (!reset)                      e_next = RST_PC;
    else if (redirect_i)             e_next = {redirect_target_i[31:2], 2'b00};
    else if (e_req && imem_gnt_i)    e_next = pc_i + 32'd4;
    else                             e_next = pc_i;
    chk("imem_req", {31'd0, imem_req_o}, {31'd0, e_req});
    chk("next_pc", next_pc_o, e_next);
    if (e_req) chk("imem_addr", imem_addr_o, pc_i);
    chk("ifid_valid", {31'd0, ifid_valid_o}, {31'd0, m_buf.size() > 0});
    if (m_buf.size() > 0) begin
      chk("ifid_instr", ifid_instr_o, m_buf[0].instr);
      chk("ifid_pc", ifid_pc_o, m_buf[0].pc);
      chk("ifid_pc4", ifid_pc4_o, m_buf[0].pc + 32'd4);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", fetch_stall_cnt_o, m_stall);
`endif
  end

  task automatic drive(input bit g, input bit rv, input bit rdy, input bit rd, input logic [31:0] tgt);
    @(posedge clk);
    #2;
    imem_gnt_i        = g;
    imem_rvalid_i     = rv && (m_inf.size() > 0);
    imem_rdata_i      = imem_rvalid_i ? mem_word(m_inf[0].pc) : $urandom;
    ifid_ready_i      = rdy;
    redirect_i        = rd;
    redirect_target_i = tgt;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    ifid_ready_i = 1'b0; redirect_i = 1'b0; redirect_target_i = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

`ifdef FETCH_PERF_CNT_EN
    // Grant held low after release: counter climbs once per empty cycle.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    chk("lit_stall_after_5", fetch_stall_cnt_o, 32'd5);
`endif

    // First fetch from the reset PC.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    chk("lit_first_req", {31'd0, imem_req_o}, 32'd1);
    chk("lit_first_next", next_pc_o, 32'h0040_0004);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    settle();
    chk("lit_not_yet_valid", {31'd0, ifid_valid_o}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    chk("lit_valid", {31'd0, ifid_valid_o}, 32'd1);
    chk("lit_instr", ifid_instr_o, 32'h2008_0005);
    chk("lit_pc", ifid_pc_o, 32'h0040_0000);
    chk("lit_pc4", ifid_pc4_o, 32'h0040_0004);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

    // Two outstanding, then redirect: both late responses dropped.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0100);
    settle();
    chk("lit_redir_next", next_pc_o, 32'h0040_0100);
    chk("lit_redir_noreq", {31'd0, imem_req_o}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    settle();
    chk("lit_redir_addr", imem_addr_o, 32'h0040_0100);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    settle();
    chk("lit_drop_valid", {31'd0, ifid_valid_o}, 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    chk("lit_redir_pc", ifid_pc_o, 32'h0040_0100);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

    // Misaligned redirect target and PC wrap-around.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0103);
    settle();
    chk("lit_align_next", next_pc_o, 32'h0040_0100);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    chk("lit_wrap_next", next_pc_o, 32'h0000_0000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    chk("lit_wrap_pc4", ifid_pc4_o, 32'h0000_0000);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

    // Decode stalled with a 1-cycle memory: credit runs out after two entries.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    settle();
    chk("lit_bp_noreq", {31'd0, imem_req_o}, 32'd0);
    chk("lit_bp_hold", next_pc_o, pc_i);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

    random_traffic(500);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #3;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0; ifid_ready_i = 1'b0;
    reset = 1'b0;
    #1;
    chk("lit_rst_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("lit_rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("lit_rst_next", next_pc_o, 32'h0040_0000);
    chk("lit_rst_pc", ifid_pc_o, 32'h0040_0000);
    chk("lit_rst_instr", ifid_instr_o, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;

    random_traffic(400);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
